// File: rtl/nios_system_nios2_cpu_debug_cmd_queue.sv
// Debug command queue: synchronizes TCK-domain toggle events, queues {ir, sr}
// snapshots in a FIFO and turns each accepted command into one-cycle action pulses.
module nios_system_nios2_cpu_debug_cmd_queue #(
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int N_BRK       = 4,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      vs_e1dr_tgl,
  input  logic                      vs_uir_tgl,
  input  logic [IR_W-1:0]           ir_in,
  input  logic [SR_W-1:0]           sr,
  input  logic                      cmd_ready,
  input  logic                      ovf_clr,
  output logic                      cmd_valid,
  output logic [IR_W-1:0]           cmd_ir,
  output logic [SR_W-1:0]           jdo,
  output logic [(2**IR_W)-1:0]      take_action,
  output logic [(2**IR_W)-1:0]      take_no_action,
  output logic [N_BRK-1:0]          brk_sel,
  output logic                      uir_evt,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow
);

  localparam int N_ACT = 2 ** IR_W;
  localparam int BRK_W = $clog2(N_BRK);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int BLK_W = $clog2(SYNC_STAGES + 2);

  typedef struct packed {
    logic [IR_W-1:0] ir;
    logic [SR_W-1:0] sr;
  } cmd_t;

  logic [SYNC_STAGES-1:0] e1dr_sync_q, uir_sync_q;
  logic                   e1dr_prev_q, uir_prev_q;
  logic [BLK_W-1:0]       blank_q;
  logic                   blank, e1dr_evt, uir_evt_w;

  // The previous-value flops keep following the last sync stage through reset,
  // so a toggle already high never looks like an edge once blanking ends.
  always_ff @(posedge clk) begin
    e1dr_prev_q <= e1dr_sync_q[SYNC_STAGES-1];
    uir_prev_q  <= uir_sync_q[SYNC_STAGES-1];
    if (reset) begin
      e1dr_sync_q <= '0;
      uir_sync_q  <= '0;
      blank_q     <= BLK_W'(SYNC_STAGES + 1);
    end else begin
      e1dr_sync_q <= {e1dr_sync_q[SYNC_STAGES-2:0], vs_e1dr_tgl};
      uir_sync_q  <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir_tgl};
      if (blank_q != '0) blank_q <= blank_q - BLK_W'(1);
    end
  end

  assign blank     = reset || (blank_q != '0);
  assign e1dr_evt  = !blank && (e1dr_sync_q[SYNC_STAGES-1] != e1dr_prev_q);
  assign uir_evt_w = !blank && (uir_sync_q[SYNC_STAGES-1] != uir_prev_q);

  cmd_t             mem_q [DEPTH];
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full, pop, push, drop;

  logic [SR_W-1:0]  jdo_q, jdo_d;
  logic [N_ACT-1:0] ta_q, ta_d, tna_q, tna_d;
  logic [N_BRK-1:0] brk_q, brk_d;
  logic             ovf_q, ovf_d;

  assign head = mem_q[rd_ptr_q];
  assign full = (level_q == LVL_W'(DEPTH));
  // Acceptance only looks at the registered level, so an entry arriving into
  // an empty queue cannot be taken in the cycle it is written.
  assign pop  = (level_q != '0) && cmd_ready;
  assign push = e1dr_evt && (!full || pop);
  assign drop = e1dr_evt && full && !pop;

  // NOTE: storage is deliberately not reset; the pointers and level decide
  // what is valid, and leaving the array out of reset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {ir_in, sr};
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
    jdo_d    = jdo_q;
    ta_d     = '0;
    tna_d    = '0;
    brk_d    = '0;
    if (pop) begin
      jdo_d = head.sr;
      if (head.sr[SR_W-1]) ta_d[head.ir]  = 1'b1;
      else                 tna_d[head.ir] = 1'b1;
      if (int'(head.ir) == 2) brk_d[head.sr[SR_W-2 -: BRK_W]] = 1'b1;
    end
    // A drop in the same cycle as a clear wins, so no overflow is ever lost.
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      jdo_q    <= '0;
      ta_q     <= '0;
      tna_q    <= '0;
      brk_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      jdo_q    <= jdo_d;
      ta_q     <= ta_d;
      tna_q    <= tna_d;
      brk_q    <= brk_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: reset is synchronous, so the registers only clear at the next edge;
  // masking the outputs with reset forces them to zero for the whole reset
  // cycle and kills a pulse that is already in flight.
  assign cmd_valid      = !reset && (level_q != '0);
  assign cmd_ir         = cmd_valid ? head.ir : '0;
  assign jdo            = reset ? '0 : jdo_q;
  assign take_action    = reset ? '0 : ta_q;
  assign take_no_action = reset ? '0 : tna_q;
  assign brk_sel        = reset ? '0 : brk_q;
  assign uir_evt        = uir_evt_w;
  assign level          = reset ? '0 : level_q;
  assign overflow       = !reset && ovf_q;

endmodule

// File: tb/tb_nios_system_nios2_cpu_debug_cmd_queue.sv
// Bench for the debug command queue: directed cases with literal expectations,
// then random traffic compared every cycle against a queue-based model.
module tb_nios_system_nios2_cpu_debug_cmd_queue;

  localparam int SR_W  = 38;
  localparam int IR_W  = 2;
  localparam int N_BRK = 4;
  localparam int DEPTH = 4;
  localparam int SS    = 2;
  localparam int N_ACT = 2 ** IR_W;
  localparam int BRK_W = $clog2(N_BRK);

  logic             clk, reset, vs_e1dr_tgl, vs_uir_tgl, cmd_ready, ovf_clr;
  logic [IR_W-1:0]  ir_in;
  logic [SR_W-1:0]  sr;
  logic             cmd_valid, uir_evt, overflow;
  logic [IR_W-1:0]  cmd_ir;
  logic [SR_W-1:0]  jdo;
  logic [N_ACT-1:0] take_action, take_no_action;
  logic [N_BRK-1:0] brk_sel;
  logic [$clog2(DEPTH):0] level;

  nios_system_nios2_cpu_debug_cmd_queue #(
    .SR_W(SR_W), .IR_W(IR_W), .N_BRK(N_BRK), .DEPTH(DEPTH), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .reset(reset), .vs_e1dr_tgl(vs_e1dr_tgl), .vs_uir_tgl(vs_uir_tgl),
    .ir_in(ir_in), .sr(sr), .cmd_ready(cmd_ready), .ovf_clr(ovf_clr),
    .cmd_valid(cmd_valid), .cmd_ir(cmd_ir), .jdo(jdo), .take_action(take_action),
    .take_no_action(take_no_action), .brk_sel(brk_sel), .uir_evt(uir_evt),
    .level(level), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [IR_W-1:0] ir;
    logic [SR_W-1:0] sr;
  } ent_t;

  ent_t             mq[$];
  logic [SR_W-1:0]  m_jdo = '0;
  logic [N_ACT-1:0] m_ta = '0, m_tna = '0;
  logic [N_BRK-1:0] m_brk = '0;
  logic             m_ovf = 1'b0;
  logic             m_ev_e = 1'b0, m_ev_u = 1'b0;
  int               since_rst = 0;
  logic             e_hist[$] = '{0, 0, 0};
  logic             u_hist[$] = '{0, 0, 0};

  // An event is visible in the cycle after edge n when the toggle value sampled
  // at edge n-SS+1 differs from the one at edge n-SS and no reset edge fell
  // within edges n-SS..n.
  always @(posedge clk) begin
    ent_t h;
    int   b;
    if (reset) begin
      mq.delete();
      m_jdo = '0; m_ta = '0; m_tna = '0; m_brk = '0; m_ovf = 1'b0;
      since_rst = 0;
    end else begin
      m_ta = '0; m_tna = '0; m_brk = '0;
      if (mq.size() > 0 && cmd_ready) begin
        h = mq.pop_front();
        m_jdo = h.sr;
        if (h.sr[SR_W-1]) m_ta  = N_ACT'(1 << h.ir);
        else              m_tna = N_ACT'(1 << h.ir);
        if (h.ir == 2) begin
          b = int'(h.sr[SR_W-2 -: BRK_W]);
          m_brk = N_BRK'(1 << b);
        end
      end
      if (m_ev_e && mq.size() >= DEPTH) m_ovf = 1'b1;
      else if (ovf_clr)                 m_ovf = 1'b0;
      if (m_ev_e && mq.size() < DEPTH) mq.push_back('{ir_in, sr});
      if (since_rst < 1000) since_rst++;
    end
    e_hist.push_front(vs_e1dr_tgl); void'(e_hist.pop_back());
    u_hist.push_front(vs_uir_tgl);  void'(u_hist.pop_back());
    m_ev_e = (since_rst > SS) && (e_hist[SS-1] != e_hist[SS]);
    m_ev_u = (since_rst > SS) && (u_hist[SS-1] != u_hist[SS]);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmd_valid", cmd_valid, !reset && mq.size() > 0);
      check("level", level, reset ? 0 : mq.size());
      check("cmd_ir", cmd_ir, (!reset && mq.size() > 0) ? mq[0].ir : '0);
      check("jdo", jdo, reset ? '0 : m_jdo);
      check("take_action", take_action, reset ? '0 : m_ta);
      check("take_no_action", take_no_action, reset ? '0 : m_tna);
      check("brk_sel", brk_sel, reset ? '0 : m_brk);
      check("uir_evt", uir_evt, !reset && m_ev_u);
      check("overflow", overflow, !reset && m_ovf);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  int rdy_pct;

  initial begin
    reset = 1'b1; vs_e1dr_tgl = 1'b0; vs_uir_tgl = 1'b0;
    cmd_ready = 1'b0; ovf_clr = 1'b0; ir_in = '0; sr = '0;
    step(1);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst level", level, 0);
    check("rst cmd_valid", cmd_valid, 0);
    check("rst jdo", jdo, 0);
    step(2);
    reset = 1'b0;
    step(SS + 3);

    // Single action command: pulse one cycle after the accepting edge.
    ir_in = 2'd0; sr = 38'h20_0000_1234; cmd_ready = 1'b1; vs_e1dr_tgl = ~vs_e1dr_tgl;
    repeat (4) @(negedge clk);
    check("A cmd_valid e3", cmd_valid, 1);
    check("A level e3", level, 1);
    @(negedge clk);
    check("A take_action", take_action, 4'b0001);
    check("A take_no_action", take_no_action, 4'b0000);
    check("A jdo", jdo, 38'h20_0000_1234);
    @(negedge clk);
    check("A pulse width", take_action, 4'b0000);
    step(3);

    // Same with the action flag clear.
    sr = 38'h00_0000_0055; vs_e1dr_tgl = ~vs_e1dr_tgl;
    repeat (5) @(negedge clk);
    check("B take_no_action", take_no_action, 4'b0001);
    check("B take_action", take_action, 4'b0000);
    step(3);

    // Break channel select on instruction 2.
    ir_in = 2'd2; sr = 38'h30_0000_0000; vs_e1dr_tgl = ~vs_e1dr_tgl;
    repeat (5) @(negedge clk);
    check("C take_action", take_action, 4'b0100);
    check("C brk_sel", brk_sel, 4'b0100);
    step(3);
    ir_in = 2'd0;

    // Overfill with the consumer stalled, then drain.
    cmd_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      sr = SR_W'(k); vs_e1dr_tgl = ~vs_e1dr_tgl;
      step(3);
    end
    @(negedge clk);
    check("D level full", level, 4);
    check("D overflow", overflow, 1);
    step(1);
    cmd_ready = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("D drain jdo", jdo, k);
    end
    check("D level empty", level, 0);
    check("D cmd_valid empty", cmd_valid, 0);
    @(negedge clk);
    check("D jdo held", jdo, 4);

    // Overflow beats a same-cycle clear; a lone clear clears.
    step(1);
    cmd_ready = 1'b0;
    for (int k = 6; k <= 9; k++) begin
      sr = SR_W'(k); vs_e1dr_tgl = ~vs_e1dr_tgl;
      step(3);
    end
    sr = SR_W'(10); vs_e1dr_tgl = ~vs_e1dr_tgl;
    step(2);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    @(negedge clk);
    check("E ovf priority", overflow, 1);
    step(1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    @(negedge clk);
    check("E ovf clear", overflow, 0);

    // Enqueue and accept together while full: level stays at DEPTH.
    step(1);
    sr = SR_W'(11); vs_e1dr_tgl = ~vs_e1dr_tgl;
    step(2);
    cmd_ready = 1'b1;
    step(1);
    @(negedge clk);
    check("F level full+both", level, 4);
    check("F jdo head", jdo, 6);
    step(6);
    @(negedge clk);
    check("F drained", level, 0);
    check("F last jdo", jdo, 11);

    // Reset with queued entries and the toggle held high.
    step(1);
    if (vs_e1dr_tgl) begin
      vs_e1dr_tgl = 1'b0;
      step(6);
    end
    cmd_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sr = SR_W'(20 + k); vs_e1dr_tgl = ~vs_e1dr_tgl;
      step(3);
    end
    reset = 1'b1;
    @(negedge clk);
    check("G in-reset level", level, 0);
    check("G in-reset valid", cmd_valid, 0);
    step(1);
    reset = 1'b0;
    cmd_ready = 1'b1;
    repeat (SS + 4) begin
      @(negedge clk);
      check("G post level", level, 0);
      check("G post valid", cmd_valid, 0);
      check("G post pulses", {take_action, take_no_action}, 0);
    end

    // Simultaneous Update-IR and Exit1-DR events.
    step(1);
    cmd_ready = 1'b0; sr = SR_W'(33);
    vs_e1dr_tgl = ~vs_e1dr_tgl; vs_uir_tgl = ~vs_uir_tgl;
    repeat (3) @(negedge clk);
    check("H uir_evt", uir_evt, 1);
    check("H level before", level, 0);
    @(negedge clk);
    check("H uir one cycle", uir_evt, 0);
    check("H level after", level, 1);

    // Reset in the pulse cycle suppresses the pulse.
    step(1);
    cmd_ready = 1'b1;
    step(1);
    reset = 1'b1;
    @(negedge clk);
    check("I suppressed pulse", take_no_action, 0);
    step(1);
    reset = 1'b0;
    step(SS + 3);

    // Random traffic against the model.
    rdy_pct = 50;
    for (int i = 0; i < 2500; i++) begin
      step(1);
      if (i % 250 == 0) rdy_pct = $urandom_range(5, 95);
      reset     = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) vs_e1dr_tgl = ~vs_e1dr_tgl;
      if ($urandom_range(0, 7) == 0) vs_uir_tgl  = ~vs_uir_tgl;
      cmd_ready = ($urandom_range(0, 99) < rdy_pct);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      ir_in     = IR_W'($urandom);
      sr        = SR_W'({$urandom, $urandom});
    end
    reset = 1'b0; ovf_clr = 1'b0; cmd_ready = 1'b1;
    step(10);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/nios_system_nios2_cpu_debug_cmd_queue.md
NIOS_SYSTEM_NIOS2_CPU_DEBUG_CMD_QUEUE -- requirements
Module: nios_system_nios2_cpu_debug_cmd_queue

Interface
REQ-001 Parameter SR_W, default 38: debug shift-register and jdo width, legal range >=8.
REQ-002 Parameter IR_W, default 2: virtual-JTAG instruction width; the block SHALL decode 2**IR_W action channels.
REQ-003 Parameter N_BRK, default 4: break channels, power of 2, range 2..8.
REQ-004 Parameter DEPTH, default 4: command FIFO depth, power of 2, range 2..16.
REQ-005 Parameter SYNC_STAGES, default 2: synchronizer flops per toggle input, range 2..4.
REQ-006 clk  in  1  single system clock; all logic SHALL be on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 vs_e1dr_tgl  in  1  TCK-domain toggle, flips once per Exit1-DR.
REQ-009 vs_uir_tgl  in  1  TCK-domain toggle, flips once per Update-IR.
REQ-010 ir_in  in  IR_W  instruction register, quasi-static around events.
REQ-011 sr  in  SR_W  shift register, quasi-static around events.
REQ-012 cmd_ready  in  1  consumer accepts the head command.
REQ-013 ovf_clr  in  1  clears the sticky overflow flag.
REQ-014 cmd_valid  out  1  FIFO non-empty.
REQ-015 cmd_ir  out  IR_W  instruction of the head entry.
REQ-016 jdo  out  SR_W  data of the last accepted command, held until the next acceptance.
REQ-017 take_action  out  2**IR_W  one-hot pulse, action flag set.
REQ-018 take_no_action  out  2**IR_W  one-hot pulse, action flag clear.
REQ-019 brk_sel  out  N_BRK  one-hot break-channel select, valid with pulses on channel 2.
REQ-020 uir_evt  out  1  one-cycle Update-IR pulse.
REQ-021 level  out  clog2(DEPTH)+1  FIFO occupancy.
REQ-022 overflow  out  1  sticky; a command was dropped.

Function
REQ-023 Each toggle input SHALL pass through a SYNC_STAGES-flop chain, followed by one flop holding the previous value; an event SHALL be the cycle in which the last sync stage differs from the previous-value flop.
REQ-024 On an e1dr event the block SHALL enqueue the entry {ir_in, sr} sampled in that cycle; it SHALL be visible at the head with cmd_valid=1 from the next edge.
REQ-025 A uir event SHALL pulse uir_evt for exactly one cycle and SHALL NOT enqueue.
REQ-026 Handshake: a command SHALL be accepted when cmd_valid and cmd_ready are both 1; cmd_ready SHALL be ignored when empty.
REQ-027 At the acceptance edge, jdo SHALL load the head data; for exactly the following cycle, exactly one bit ir of take_action (jdo[SR_W-1]=1) or of take_no_action (jdo[SR_W-1]=0) SHALL be 1.
REQ-028 brk_sel SHALL be registered with the pulse; it SHALL be the one-hot decode of jdo[SR_W-2 -: clog2(N_BRK)] when ir==2, and zero otherwise.
REQ-029 FIFO SHALL be strictly in-order, and back-to-back acceptance SHALL sustain one command per cycle.
REQ-030 Enqueue while full without a same-cycle acceptance SHALL drop the entry and set overflow; enqueue and acceptance in the same cycle while full SHALL both succeed, leaving level unchanged.
REQ-031 Enqueue and acceptance in the same cycle while empty SHALL enqueue only; the new entry SHALL be accepted no earlier than the next cycle.
REQ-032 level SHALL equal the number of stored entries, and SHALL NOT exceed DEPTH or underflow.
REQ-033 ovf_clr SHALL clear overflow; a same-cycle overflow event SHALL take priority and leave overflow at 1.
REQ-034 Simultaneous e1dr and uir events SHALL both be serviced in the same cycle.

Reset
REQ-035 While reset=1, the following SHALL be 0: cmd_valid, cmd_ir, jdo, take_action, take_no_action, brk_sel, uir_evt, level and overflow; FIFO pointers SHALL be 0 and queued entries SHALL be discarded.
REQ-036 While reset=1 and for SYNC_STAGES+1 cycles after its release, event detection SHALL be blanked, with the previous-value flops tracking the last sync stage so that a toggle input already at 1 produces no spurious event.
REQ-037 A reset asserted in the cycle after an acceptance SHALL suppress that acceptance's pulse.

Verification (defaults)
REQ-038 ir_in=0, sr=38'h20_0000_1234, cmd_ready=1, flip vs_e1dr_tgl -> event after edge 2, cmd_valid from edge 3, take_action=4'b0001 for one cycle after edge 4, jdo=38'h20_0000_1234.
REQ-039 Same with sr=38'h00_0000_0055 -> take_no_action=4'b0001 only, take_action=0.
REQ-040 ir_in=2, sr[37]=1, sr[36:35]=2'b10 -> take_action=4'b0100 with brk_sel=4'b0100.
REQ-041 cmd_ready=0, five e1dr events with sr=1..5 -> level=4, overflow=1; then cmd_ready=1 -> jdo 1,2,3,4 on consecutive cycles, 5 is absent, level=0.
REQ-042 Three entries queued, then reset for 1 cycle with vs_e1dr_tgl=1 held -> level=0, cmd_valid=0, no pulses and no new event after release.
REQ-043 Flip vs_uir_tgl and vs_e1dr_tgl together -> uir_evt and enqueue occur in the same cycle, level=1.
